ahb_vec_fetch: RTL
==================

# ahb_vec_fetch

AHB-lite single-transfer read initiator that fetches exception/interrupt vector words from the vector-table responder on the memss AHB-lite segment. After reset it autonomously fetches the initial stack pointer (offset 0x0) and the reset vector (offset 0x4). It then serves vector lookups from a core-side request/response port, one non-sequential word read per request. It handles responder wait states and the two-cycle AHB ERROR response, and keeps an error statistic.

## Interface
- BASE_ADDR, 32'h0000_0000, base byte address of the vector table
- hclk  in  1  clock
- hresetn  in  1  reset, asynchronous, active-low
- hsel  out  1  responder select; high only in address phase
- haddr  out  32  transfer address; 0 when not in address phase
- htrans  out  2  2'b10 NONSEQ in address phase, else 2'b00 IDLE
- hsize  out  3  constant 3'b010 (word)
- hwrite  out  1  constant 0
- hrdata  in  32  responder read data
- hready  in  1  responder ready
- hresp  in  1  responder error
- req  in  1  vector lookup request (level, held until req_ack)
- req_id  in  5  vector index; byte offset = {req_id,2'b00} (0 SP, 1 reset, 2 NMI, 3 fault, 16..31 IRQ0..IRQ15)
- req_ack  out  1  one-cycle pulse: request accepted, req_id latched
- rsp_valid  out  1  one-cycle pulse: rsp_data/rsp_err valid
- rsp_data  out  32  fetched vector; 0 on error
- rsp_err  out  1  transfer ended with ERROR response
- sp_val  out  32  boot-fetched stack pointer
- pc_val  out  32  boot-fetched reset vector
- boot_done  out  1  boot fetches complete (sticky until reset)
- boot_err  out  1  either boot fetch errored (sticky until reset)
- err_cnt  out  8  saturating count of ERROR responses

## Operation
- One-hot state register. States: RST, SP_A, SP_D, PC_A, PC_D, IDLE, ADDR, DATA.
- Address-phase states (SP_A, PC_A, ADDR): hsel=1, htrans=NONSEQ, haddr = BASE_ADDR+0x0 / +0x4 / +{25'b0,id_q,2'b00}. These outputs are decoded from the state; every other state drives hsel=0, htrans=IDLE, haddr=0.
- RST → SP_A unconditionally.
- x_A → x_D when hready=1; otherwise hold, with address and control stable.
- Data-phase states (SP_D, PC_D, DATA) complete on the cycle hready=1:
  - hresp=0: capture hrdata.
  - hresp=1: discard hrdata, flag error, increment err_cnt (saturates at 255).
- hready=0 with hresp=1 is the first ERROR cycle: remain in the data phase with htrans IDLE. No new transfer is ever issued there.
- Data-phase successors: SP_D → PC_A; PC_D → IDLE with boot_done set; DATA → IDLE.
- Boot errors set boot_err and leave sp_val or pc_val at 0. Boot continues either way.
- IDLE with req=1 and boot_done=1: pulse req_ack, latch req_id into id_q, go to ADDR. req is ignored before boot_done.
- DATA completion: next cycle rsp_valid=1 with rsp_data=hrdata (or 0) and rsp_err=hresp. rsp_data and rsp_err hold until the next rsp_valid.
- Only one transfer is outstanding at a time; there is no address/data overlap and no bursts.

## Timing
- Reset values: hsel 0, haddr 0, htrans 0, hsize 3'b010, hwrite 0, req_ack 0, rsp_valid 0, rsp_data 0, rsp_err 0, sp_val 0, pc_val 0, boot_done 0, boot_err 0, err_cnt 0, state RST.
- Boot with zero wait states, counting cycles from the first edge after reset release:
  - cycle 1: SP_A
  - cycle 2: SP_D
  - cycle 3: PC_A
  - cycle 4: PC_D
  - cycle 5: sp_val valid from cycle 3; pc_val and boot_done valid.
- Request with zero wait states, req sampled high in IDLE at edge N:
  - req_ack high in cycle N+1, concurrent with ADDR
  - DATA in cycle N+2
  - rsp_valid in cycle N+3
  - next req acceptable at the edge ending cycle N+3 (IDLE)
- Each responder wait cycle adds one cycle to the affected phase.
- ERROR response (hready 0/hresp 1, then hready 1/hresp 1) adds one cycle. rsp_err=1 follows the second ERROR cycle.
- Reset asserted mid-transfer: all outputs go to reset values immediately and boot restarts after release.

## Test plan
- Boot, zero waits, responder returns 0x2000_1000 / 0x0000_0101 → sp_val=0x2000_1000, pc_val=0x0000_0101, boot_done high in cycle 5, boot_err=0.
- req_id=18 (IRQ2), BASE_ADDR=0 → haddr=0x48 with htrans=2'b10 for exactly one cycle; rsp_valid 3 cycles after req sample; rsp_data equals the responder word; rsp_err=0.
- Responder inserts 3 wait cycles in the address phase and 2 in the data phase → haddr/htrans held stable throughout; rsp_valid delayed by 5 cycles.
- Two-cycle ERROR on req_id=9 → htrans=IDLE in both error cycles, rsp_err=1, rsp_data=0, err_cnt=1. A following req_id=1 fetches normally.
- 300 consecutive ERROR fetches → err_cnt saturates at 255; boot error on SP → boot_err=1, sp_val=0, boot_done=1.
- req held high during boot and hresetn pulsed low mid-DATA → no req_ack before boot_done; all outputs at reset values during reset; boot sequence restarts after release.

Source files
------------

// File: rtl/ahb_vec_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ahb_vec_fetch
// Brief    : AHB-lite single-read initiator that boot-fetches SP/reset vector
//            and then serves core-side vector lookups.
// Revision : 1.0
// ============================================================================
module ahb_vec_fetch #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        hclk,
    input  logic        hresetn,
    output logic        hsel,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic [2:0]  hsize,
    output logic        hwrite,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp,
    input  logic        req,
    input  logic [4:0]  req_id,
    output logic        req_ack,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] sp_val,
    output logic [31:0] pc_val,
    output logic        boot_done,
    output logic        boot_err,
    output logic [7:0]  err_cnt
);

    localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] C_HSIZE_WORD    = 3'b010;

    typedef enum logic [7:0] {
        ST_RST  = 8'b0000_0001,
        ST_SP_A = 8'b0000_0010,
        ST_SP_D = 8'b0000_0100,
        ST_PC_A = 8'b0000_1000,
        ST_PC_D = 8'b0001_0000,
        ST_IDLE = 8'b0010_0000,
        ST_ADDR = 8'b0100_0000,
        ST_DATA = 8'b1000_0000
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_id_q;
    logic        w_accept;
    logic        w_complete;

    assign hsize  = C_HSIZE_WORD;
    assign hwrite = 1'b0;

    // A data phase ends on hready; the first ERROR cycle (hready=0) just holds.
    assign w_complete = hready && ((r_state == ST_SP_D) ||
                                   (r_state == ST_PC_D) ||
                                   (r_state == ST_DATA));

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        hsel         = 1'b0;
        htrans       = C_HTRANS_IDLE;
        haddr        = 32'h0;
        case (r_state)
            ST_RST: begin
                w_next_state = ST_SP_A;
            end
            ST_SP_A: begin
                hsel   = 1'b1;
                htrans = C_HTRANS_NONSEQ;
                haddr  = BASE_ADDR;
                if (hready) w_next_state = ST_SP_D;
            end
            ST_SP_D: begin
                if (hready) w_next_state = ST_PC_A;
            end
            ST_PC_A: begin
                hsel   = 1'b1;
                htrans = C_HTRANS_NONSEQ;
                haddr  = BASE_ADDR + 32'h4;
                if (hready) w_next_state = ST_PC_D;
            end
            ST_PC_D: begin
                if (hready) w_next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (req && boot_done) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ADDR;
                end
            end
            ST_ADDR: begin
                hsel   = 1'b1;
                htrans = C_HTRANS_NONSEQ;
                haddr  = BASE_ADDR + {25'b0, r_id_q, 2'b00};
                if (hready) w_next_state = ST_DATA;
            end
            ST_DATA: begin
                if (hready) w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_RST;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state   <= ST_RST;
            r_id_q    <= 5'd0;
            req_ack   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_err   <= 1'b0;
            sp_val    <= 32'h0;
            pc_val    <= 32'h0;
            boot_done <= 1'b0;
            boot_err  <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            r_state   <= w_next_state;
            req_ack   <= w_accept;
            rsp_valid <= 1'b0;

            if (w_accept) r_id_q <= req_id;

            if (w_complete && hresp && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            if (w_complete) begin
                case (r_state)
                    ST_SP_D: begin
                        if (hresp) boot_err <= 1'b1;
                        else       sp_val   <= hrdata;
                    end
                    ST_PC_D: begin
                        boot_done <= 1'b1;
                        if (hresp) boot_err <= 1'b1;
                        else       pc_val   <= hrdata;
                    end
                    ST_DATA: begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= hresp ? 32'h0 : hrdata;
                        rsp_err   <= hresp;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
